// File: rtl/arm_control_unit.sv
// Multi-cycle microsequencer for the ARM datapath: fetch, decode, condition check and
// execute for data-processing, immediate-offset LDR/STR(B) and B/BL, with a MFC watchdog.
module arm_control_unit #(
    parameter int MFC_TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [31:0] IR,
    input  logic        MFC,
    input  logic [3:0]  Flags,
    output logic        MFA,
    output logic        RW_RAM,
    output logic        SALU,
    output logic        RF_CLR,
    output logic        RF_RW,
    output logic        SSAB,
    output logic        SSOP,
    output logic        SMA,
    output logic        STA,
    output logic        MAR_EN,
    output logic        SR_EN,
    output logic        SE_EN,
    output logic        MDR_EN,
    output logic        SHT_EN,
    output logic        IR_EN,
    output logic        SGN_EN,
    output logic [1:0]  DataSize,
    output logic [1:0]  WRA,
    output logic [1:0]  SRA,
    output logic [1:0]  SRB,
    output logic [1:0]  SISE,
    output logic [1:0]  SALUB,
    output logic [3:0]  ALUA,
    output logic        FAULT,
    output logic [4:0]  STATE
);

    localparam logic [4:0] S_RESET  = 5'd0;
    localparam logic [4:0] S_FETCH1 = 5'd1;
    localparam logic [4:0] S_FETCH2 = 5'd2;
    localparam logic [4:0] S_FWAIT  = 5'd3;
    localparam logic [4:0] S_LOADIR = 5'd4;
    localparam logic [4:0] S_DECODE = 5'd5;
    localparam logic [4:0] S_DP     = 5'd6;
    localparam logic [4:0] S_LSADDR = 5'd7;
    localparam logic [4:0] S_LDREQ  = 5'd8;
    localparam logic [4:0] S_LDWAIT = 5'd9;
    localparam logic [4:0] S_LDWB   = 5'd10;
    localparam logic [4:0] S_STDATA = 5'd11;
    localparam logic [4:0] S_STREQ  = 5'd12;
    localparam logic [4:0] S_STWAIT = 5'd13;
    localparam logic [4:0] S_BL     = 5'd14;
    localparam logic [4:0] S_BR     = 5'd15;
    localparam logic [4:0] S_FAULT  = 5'd31;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_MOV = 4'b1101;

    localparam logic [7:0] WD_LAST = 8'(MFC_TIMEOUT - 1);

    logic [4:0] state_q, state_d;
    logic [7:0] wdog_q, wdog_d;
    logic [1:0] ls_size;
    logic       unused_ir;

    assign unused_ir = ^{IR[21], IR[19:0]};
    assign ls_size   = IR[22] ? 2'b00 : 2'b10;
    assign STATE     = state_q;

    // ARM condition field against {N,Z,C,V}
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0: cond_pass = z;
            4'h1: cond_pass = ~z;
            4'h2: cond_pass = c;
            4'h3: cond_pass = ~c;
            4'h4: cond_pass = n;
            4'h5: cond_pass = ~n;
            4'h6: cond_pass = v;
            4'h7: cond_pass = ~v;
            4'h8: cond_pass = c & ~z;
            4'h9: cond_pass = ~c | z;
            4'hA: cond_pass = (n == v);
            4'hB: cond_pass = (n != v);
            4'hC: cond_pass = ~z & (n == v);
            4'hD: cond_pass = z | (n != v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_RESET;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
        end
    end

    // The watchdog sits at zero outside wait states, so every wait state is entered cleared.
    always_comb begin
        state_d = state_q;
        wdog_d  = '0;
        case (state_q)
            S_RESET:  state_d = S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_FWAIT;
            S_FWAIT, S_LDWAIT, S_STWAIT: begin
                if (MFC) begin
                    if (state_q == S_FWAIT)       state_d = S_LOADIR;
                    else if (state_q == S_LDWAIT) state_d = S_LDWB;
                    else                          state_d = S_FETCH1;
                end else if (wdog_q >= WD_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            S_LOADIR: state_d = S_DECODE;
            S_DECODE: begin
                if (!cond_pass(IR[31:28], Flags))       state_d = S_FETCH1;
                else if (IR[27:26] == 2'b00)            state_d = S_DP;
                else if (IR[27:26] == 2'b01)            state_d = S_LSADDR;
                else if (IR[27:26] == 2'b10 && IR[25])  state_d = IR[24] ? S_BL : S_BR;
                else                                    state_d = S_FAULT;
            end
            S_DP:     state_d = S_FETCH1;
            S_LSADDR: state_d = IR[20] ? S_LDREQ : S_STDATA;
            S_LDREQ:  state_d = S_LDWAIT;
            S_LDWB:   state_d = S_FETCH1;
            S_STDATA: state_d = S_STREQ;
            S_STREQ:  state_d = S_STWAIT;
            S_BL:     state_d = S_BR;
            S_BR:     state_d = S_FETCH1;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
        endcase
    end

    always_comb begin
        MFA = 1'b0;     RW_RAM = 1'b0;  SALU = 1'b0;    RF_CLR = 1'b0;
        RF_RW = 1'b0;   SSAB = 1'b0;    SSOP = 1'b0;    SMA = 1'b0;
        STA = 1'b0;     MAR_EN = 1'b0;  SR_EN = 1'b0;   SE_EN = 1'b0;
        MDR_EN = 1'b0;  SHT_EN = 1'b0;  IR_EN = 1'b0;   SGN_EN = 1'b0;
        DataSize = 2'd0; WRA = 2'd0;    SRA = 2'd0;     SRB = 2'd0;
        SISE = 2'd0;    SALUB = 2'd0;   ALUA = 4'd0;    FAULT = 1'b0;
        case (state_q)
            S_RESET: RF_CLR = 1'b1;
            S_FETCH1: begin
                SRB = 2'd1; SSOP = 1'b1; SHT_EN = 1'b1; SALUB = 2'd3; ALUA = ALU_MOV;
                MAR_EN = 1'b1;
            end
            S_FETCH2: begin
                SRA = 2'd1; SALUB = 2'd1; ALUA = ALU_ADD; WRA = 2'd1; RF_RW = 1'b1;
                MFA = 1'b1; RW_RAM = 1'b1; DataSize = 2'b10;
            end
            S_FWAIT: begin
                MFA = 1'b1; RW_RAM = 1'b1; SMA = 1'b1; MDR_EN = 1'b1; DataSize = 2'b10;
            end
            S_LOADIR: IR_EN = 1'b1;
            // Compare/test opcodes (IR[24:23]=10) only update flags
            S_DP: begin
                SALU = 1'b1; SRB = 2'd3; SSOP = ~IR[25]; SE_EN = IR[25]; SHT_EN = 1'b1;
                STA = ~IR[25]; SALUB = 2'd3; RF_RW = (IR[24:23] != 2'b10); SR_EN = IR[20];
            end
            S_LSADDR: begin
                SE_EN = 1'b1; SISE = 2'b01; SALUB = 2'd3;
                ALUA = IR[23] ? ALU_ADD : ALU_SUB; MAR_EN = 1'b1;
            end
            S_LDREQ, S_LDWAIT: begin
                MFA = 1'b1; RW_RAM = 1'b1; SMA = 1'b1; MDR_EN = 1'b1; SGN_EN = 1'b1;
                DataSize = ls_size;
            end
            S_LDWB: begin
                SALUB = 2'd0; ALUA = ALU_MOV; RF_RW = 1'b1;
            end
            S_STDATA: begin
                SRB = 2'd2; SSOP = 1'b1; SHT_EN = 1'b1; SALUB = 2'd3; ALUA = ALU_MOV;
                MDR_EN = 1'b1;
            end
            S_STREQ, S_STWAIT: begin
                MFA = 1'b1; DataSize = ls_size;
            end
            S_BL: begin
                SRB = 2'd1; SSOP = 1'b1; SHT_EN = 1'b1; SALUB = 2'd3; ALUA = ALU_MOV;
                WRA = 2'd2; RF_RW = 1'b1;
            end
            S_BR: begin
                SRA = 2'd1; SALUB = 2'd2; ALUA = ALU_ADD; WRA = 2'd1; RF_RW = 1'b1;
            end
            S_FAULT: FAULT = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arm_control_unit.sv
// Randomized bench: builds an expected cycle-by-cycle control trace per instruction, then
// replays it against the DUT, comparing every output on every cycle.
module tb_arm_control_unit;
    localparam int T = 16;

    logic        CLK = 1'b0;
    logic        CLR, MFC;
    logic [31:0] IR;
    logic [3:0]  Flags;
    logic MFA, RW_RAM, SALU, RF_CLR, RF_RW, SSAB, SSOP, SMA, STA, MAR_EN, SR_EN, SE_EN;
    logic MDR_EN, SHT_EN, IR_EN, SGN_EN, FAULT;
    logic [1:0] DataSize, WRA, SRA, SRB, SISE, SALUB;
    logic [3:0] ALUA;
    logic [4:0] STATE;

    arm_control_unit #(.MFC_TIMEOUT(T)) dut (
        .CLK(CLK), .CLR(CLR), .IR(IR), .MFC(MFC), .Flags(Flags),
        .MFA(MFA), .RW_RAM(RW_RAM), .SALU(SALU), .RF_CLR(RF_CLR), .RF_RW(RF_RW),
        .SSAB(SSAB), .SSOP(SSOP), .SMA(SMA), .STA(STA), .MAR_EN(MAR_EN), .SR_EN(SR_EN),
        .SE_EN(SE_EN), .MDR_EN(MDR_EN), .SHT_EN(SHT_EN), .IR_EN(IR_EN), .SGN_EN(SGN_EN),
        .DataSize(DataSize), .WRA(WRA), .SRA(SRA), .SRB(SRB), .SISE(SISE), .SALUB(SALUB),
        .ALUA(ALUA), .FAULT(FAULT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic mfa, rw_ram, salu, rf_clr, rf_rw, ssab, ssop, sma, sta, mar_en, sr_en, se_en;
        logic mdr_en, sht_en, ir_en, sgn_en;
        logic [1:0] data_size, wra, sra, srb, sise, salub;
        logic [3:0] alua;
        logic fault;
        logic [4:0] state;
    } ctl_t;

    typedef struct {
        ctl_t        exp;
        logic        mfc;
        logic        clr;
        logic [31:0] ir;
        logic [3:0]  flags;
        int          tag;
        bit          start;
    } step_t;

    ctl_t dut_ctl;
    assign dut_ctl = {MFA, RW_RAM, SALU, RF_CLR, RF_RW, SSAB, SSOP, SMA, STA, MAR_EN, SR_EN,
                      SE_EN, MDR_EN, SHT_EN, IR_EN, SGN_EN, DataSize, WRA, SRA, SRB, SISE,
                      SALUB, ALUA, FAULT, STATE};

    step_t       q[$];
    logic [31:0] cur_ir;
    logic [3:0]  cur_flags;
    bit          cur_start;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic rbit();
        return logic'($urandom % 2);
    endfunction

    function automatic ctl_t st(input int s);
        ctl_t c = '0;
        c.state = 5'(s);
        c.fault = (s == 31);
        return c;
    endfunction

    function automatic ctl_t pass_x(input ctl_t ci, input logic [1:0] x);
        ctl_t c = ci;
        c.srb = x; c.ssop = 1'b1; c.sht_en = 1'b1; c.sta = 1'b0; c.ssab = 1'b0;
        c.salub = 2'd3; c.alua = 4'b1101;
        return c;
    endfunction

    // Truth of each ARM condition in terms of the flags it names
    function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] f);
        bit n = f[3], z = f[2], c = f[1], v = f[0];
        bit ge = (n == v);
        case (cond)
            4'h0: return z;        4'h1: return !z;
            4'h2: return c;        4'h3: return !c;
            4'h4: return n;        4'h5: return !n;
            4'h6: return v;        4'h7: return !v;
            4'h8: return c && !z;  4'h9: return !c || z;
            4'hA: return ge;       4'hB: return !ge;
            4'hC: return !z && ge; 4'hD: return z || !ge;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input ctl_t c, input logic mfc, input logic clr, input int lit);
        step_t s;
        s.exp = c; s.mfc = mfc; s.clr = clr; s.ir = cur_ir; s.flags = cur_flags;
        s.tag = (lit > 0) ? lit * 100 + int'(c.state) : 0;
        s.start = cur_start;
        cur_start = 0;
        q.push_back(s);
    endtask

    task automatic add_fault(input int lit, input int n);
        for (int i = 0; i < n; i++) push(st(31), rbit(), 1'b0, lit);
        push(st(31), rbit(), 1'b1, lit);
        begin
            ctl_t r = st(0);
            r.rf_clr = 1'b1;
            push(r, rbit(), 1'b0, lit);
        end
    endtask

    // w cycles without MFC, then MFC; more than the watchdog allows ends in FAULT
    task automatic wait_steps(input ctl_t c, input int w, input int lit, output bit ok);
        for (int i = 0; i < w && i < T; i++) push(c, 1'b0, 1'b0, lit);
        ok = (w < T);
        if (ok) push(c, 1'b1, 1'b0, lit);
    endtask

    task automatic run_instr(input logic [31:0] ir, input logic [3:0] fl,
                             input int wf, input int wm, input int lit);
        ctl_t c;
        bit   ok;
        logic [1:0] sz;
        cur_ir = ir; cur_flags = fl; cur_start = 1;
        sz = ir[22] ? 2'b00 : 2'b10;
        c = pass_x(st(1), 2'd1); c.mar_en = 1; push(c, rbit(), 0, lit);
        c = st(2); c.sra = 1; c.salub = 1; c.alua = 4'b0100; c.wra = 1; c.rf_rw = 1;
        c.mfa = 1; c.rw_ram = 1; c.data_size = 2'b10; push(c, rbit(), 0, lit);
        c = st(3); c.mfa = 1; c.rw_ram = 1; c.sma = 1; c.mdr_en = 1; c.data_size = 2'b10;
        wait_steps(c, wf, lit, ok);
        if (!ok) begin add_fault(lit, 3); return; end
        c = st(4); c.ir_en = 1; push(c, rbit(), 0, lit);
        push(st(5), rbit(), 0, lit);
        if (!cond_ok(ir[31:28], fl)) return;
        if (ir[27:26] == 2'b00) begin
            c = st(6); c.salu = 1; c.srb = 3; c.ssop = ~ir[25]; c.se_en = ir[25];
            c.sht_en = 1; c.sta = ~ir[25]; c.salub = 3; c.rf_rw = (ir[24:23] != 2'b10);
            c.sr_en = ir[20]; push(c, rbit(), 0, lit);
        end else if (ir[27:26] == 2'b01) begin
            c = st(7); c.se_en = 1; c.sise = 2'b01; c.salub = 3;
            c.alua = ir[23] ? 4'b0100 : 4'b0010; c.mar_en = 1; push(c, rbit(), 0, lit);
            if (ir[20]) begin
                c = st(8); c.mfa = 1; c.rw_ram = 1; c.sma = 1; c.mdr_en = 1; c.sgn_en = 1;
                c.data_size = sz; push(c, rbit(), 0, lit);
                c.state = 5'd9; wait_steps(c, wm, lit, ok);
                if (!ok) begin add_fault(lit, 2); return; end
                c = st(10); c.alua = 4'b1101; c.rf_rw = 1; push(c, rbit(), 0, lit);
            end else begin
                c = pass_x(st(11), 2'd2); c.mdr_en = 1; push(c, rbit(), 0, lit);
                c = st(12); c.mfa = 1; c.data_size = sz; push(c, rbit(), 0, lit);
                c.state = 5'd13; wait_steps(c, wm, lit, ok);
                if (!ok) begin add_fault(lit, 2); return; end
            end
        end else if (ir[27:26] == 2'b10 && ir[25]) begin
            if (ir[24]) begin
                c = pass_x(st(14), 2'd1); c.wra = 2; c.rf_rw = 1; push(c, rbit(), 0, lit);
            end
            c = st(15); c.sra = 1; c.salub = 2; c.alua = 4'b0100; c.wra = 1; c.rf_rw = 1;
            push(c, rbit(), 0, lit);
        end else begin
            add_fault(lit, 2);
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Hand-computed values for the directed instructions, independent of the trace model
    task automatic lit_checks(input int tag);
        case (tag)
            900: begin check("rst_rfclr", 64'(RF_CLR), 1); check("rst_state", 64'(STATE), 0); end
            106: begin
                check("add_state", 64'(STATE), 6);  check("add_salu", 64'(SALU), 1);
                check("add_ssop", 64'(SSOP), 0);    check("add_rfrw", 64'(RF_RW), 1);
                check("add_wra", 64'(WRA), 0);      check("add_sren", 64'(SR_EN), 0);
            end
            206: begin
                check("cmp_state", 64'(STATE), 6);  check("cmp_rfrw", 64'(RF_RW), 0);
                check("cmp_sren", 64'(SR_EN), 1);
            end
            307: begin check("ldrb_alua", 64'(ALUA), 4); check("ldrb_st", 64'(STATE), 7); end
            308: check("ldrb_size", 64'(DataSize), 0);
            310: begin check("ldwb_rfrw", 64'(RF_RW), 1); check("ldwb_salub", 64'(SALUB), 0); end
            414: begin check("bl_wra", 64'(WRA), 2); check("bl_rfrw", 64'(RF_RW), 1); end
            415: begin check("br_salub", 64'(SALUB), 2); check("br_wra", 64'(WRA), 1); end
            531: begin check("to_fault", 64'(FAULT), 1); check("to_state", 64'(STATE), 31); end
            500: begin check("to_rst_mfa", 64'(MFA), 0); check("to_rst_clr", 64'(RF_CLR), 1); end
            default: ;
        endcase
    endtask

    initial begin
        ctl_t r;
        logic [31:0] ir;
        logic [3:0]  cond;
        int          cls, wf, wm, ninstr;

        cur_ir = 32'h0; cur_flags = 4'h0; cur_start = 0;
        r = st(0); r.rf_clr = 1;
        push(r, 1'b0, 1'b1, 9);
        push(r, 1'b0, 1'b0, 9);
        run_instr(32'hE2811005, 4'b0000, 1, 0, 1);
        run_instr(32'h01500000, 4'b0000, 0, 0, 2);
        run_instr(32'h01500000, 4'b0100, 0, 0, 2);
        run_instr(32'hE5D12004, 4'b0000, 1, 3, 3);
        run_instr(32'hEB000010, 4'b0000, 0, 0, 4);
        run_instr(32'hE1A00001, 4'b0000, T, 0, 5);
        run_instr(32'hE1A00001, 4'b0000, T - 1, 0, 0);
        run_instr(32'hE5912000, 4'b0000, 0, T, 0);
        run_instr(32'hE5812000, 4'b0000, 0, T - 1, 0);
        run_instr(32'hEE000000, 4'b0000, 0, 0, 0);
        // CLR in the middle of a fetch wait
        cur_start = 1;
        r = pass_x(st(1), 2'd1); r.mar_en = 1; push(r, 1'b0, 1'b0, 0);
        r = st(2); r.sra = 1; r.salub = 1; r.alua = 4'b0100; r.wra = 1; r.rf_rw = 1;
        r.mfa = 1; r.rw_ram = 1; r.data_size = 2'b10; push(r, 1'b0, 1'b0, 0);
        r = st(3); r.mfa = 1; r.rw_ram = 1; r.sma = 1; r.mdr_en = 1; r.data_size = 2'b10;
        push(r, 1'b0, 1'b1, 0);
        r = st(0); r.rf_clr = 1; push(r, 1'b0, 1'b0, 0);

        for (int k = 0; k < 60; k++) begin
            ir   = $urandom;
            cond = ($urandom % 2) ? 4'hE : 4'($urandom);
            ir[31:28] = cond;
            cls = $urandom % 8;
            if (cls <= 2)      ir[27:26] = 2'b00;
            else if (cls <= 4) begin ir[27:26] = 2'b01; ir[25] = 1'b0; end
            else if (cls <= 6) begin ir[27:25] = 3'b101; ir[24] = (cls == 6); end
            else if ($urandom % 2) ir[27:26] = 2'b11;
            else               ir[27:25] = 3'b100;
            wf = ($urandom % 16 == 0) ? int'($urandom_range(T - 2, T + 1)) : int'($urandom % 4);
            wm = ($urandom % 16 == 0) ? int'($urandom_range(T - 2, T + 1)) : int'($urandom % 4);
            run_instr(ir, 4'($urandom), wf, wm, 0);
        end

        ninstr = 0;
        CLR = 1'b1; MFC = 1'b0; IR = 32'h0; Flags = 4'h0;
        @(posedge CLK);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge CLK);
            IR = q[i].ir; Flags = q[i].flags; MFC = q[i].mfc; CLR = q[i].clr;
            if (q[i].start) begin
                ninstr++;
                $display("instr %0d ir=%h flags=%b", ninstr, q[i].ir, q[i].flags);
            end
            #1;
            check($sformatf("ctl step %0d state %0d", i, q[i].exp.state), 64'(dut_ctl),
                  64'(q[i].exp));
            lit_checks(q[i].tag);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
